// File: rtl/pm_row_sched.sv
// rtl/pm_row_sched.sv - row scheduler feeding parallel_mult, with a credit-limited result FIFO
// Rows are issued only while FIFO entries plus in-flight rows leave room, so results never drop.
module pm_row_sched #(
  parameter int ADDR_W     = 10,
  parameter int MULT_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_rows,
  output logic              busy,
  output logic              done,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [15:0]       w_data,
  output logic              pm_en,
  output logic [15:0]       pm_weight_bits,
  input  logic [15:0]       pm_final_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [7:0]        res_idx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [7:0]             num_q, num_d;
  logic [7:0]             issued_q, issued_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [MULT_LAT:0]      tap_v_q;
  logic [MULT_LAT:0][7:0] tap_idx_q;
  logic [15:0]            fifo_data_q [FIFO_DEPTH];
  logic [7:0]             fifo_idx_q  [FIFO_DEPTH];
  logic                   fifo_wr, fifo_rd;
  logic [CW:0]            occupancy;

  assign fifo_wr   = tap_v_q[MULT_LAT];
  assign res_valid = (count_q != '0);
  assign fifo_rd   = res_valid & res_ready;

  // An entry popped this cycle frees its slot before any newly issued row can land.
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q} - {{CW{1'b0}}, fifo_rd};

  assign w_rd   = (state_q == S_RUN) && (issued_q < num_q) && (occupancy < DEPTH_C);
  assign w_addr = w_rd ? (base_q + ADDR_W'(issued_q)) : '0;

  assign pm_en          = tap_v_q[0];
  assign pm_weight_bits = pm_en ? w_data : '0;

  assign res_data = res_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign res_idx  = res_valid ? fifo_idx_q[rd_ptr_q] : '0;
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_FIN);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_rows;
          issued_d = '0;
          state_d  = (num_rows == 8'd0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_rd) begin
          issued_d = issued_q + 8'd1;
          if (issued_q == num_q - 8'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 && (count_q == '0 || (count_q == CW'(1) && fifo_rd)))
          state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
    inflight_d = inflight_q + CW'(w_rd) - CW'(fifo_wr);
    count_d    = count_q + CW'(fifo_wr) - CW'(fifo_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tap_v_q    <= '0;
      tap_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q + PW'(fifo_wr);
      rd_ptr_q   <= rd_ptr_q + PW'(fifo_rd);
      // Stage 0 lines up with pm_en; the last stage lines up with a valid FinalOut.
      tap_v_q    <= {tap_v_q[MULT_LAT-1:0], w_rd};
      tap_idx_q  <= {tap_idx_q[MULT_LAT-1:0], issued_q};
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data_q[wr_ptr_q] <= pm_final_out;
      fifo_idx_q[wr_ptr_q]  <= tap_idx_q[MULT_LAT];
    end
  end

endmodule

// File: tb/tb_pm_row_sched.sv
// tb/tb_pm_row_sched.sv - directed bench with a result scoreboard for pm_row_sched
module tb_pm_row_sched;
  localparam int MULT_LAT = 2;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [7:0]  num_rows = '0;
  logic [15:0] w_data = '0;
  logic [15:0] pm_final_out;
  logic        res_ready = 1'b0;
  logic        busy, done, w_rd, pm_en, res_valid;
  logic [9:0]  w_addr;
  logic [15:0] pm_weight_bits, res_data;
  logic [7:0]  res_idx;

  always #5 clk = ~clk;

  pm_row_sched #(.ADDR_W(10), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .pm_en(pm_en), .pm_weight_bits(pm_weight_bits), .pm_final_out(pm_final_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
  );

  typedef struct packed { logic [15:0] d; logic [7:0] i; } res_t;

  logic [15:0] mem [1024];
  logic [15:0] pm_pipe [MULT_LAT];
  int   cyc = 0, tests = 0, fails = 0;
  int   t0 = 0, exp_base = 0, exp_n = 0, n_issued = 0, n_popped = 0, busy_cnt = 0;
  logic prev_rd = 1'b0;
  logic [9:0] prev_addr = '0;
  res_t exp_q[$];
  int   wrd_rel[$], wrd_addr[$], res_rel[$], res_idx_q[$], done_rel[$];

  function automatic logic [15:0] pm_func(input logic [15:0] w);
    logic [15:0] acc = 16'h0;
    for (int i = 0; i < 16; i++) acc = w[i] ? acc + (16'(i) + 16'h27CF) : acc - (16'(i) + 16'h27CF);
    return acc;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (w_rd) w_data <= mem[w_addr];
  always @(posedge clk) begin
    pm_pipe[0] <= pm_en ? pm_func(pm_weight_bits) : 16'h0;
    for (int i = 1; i < MULT_LAT; i++) pm_pipe[i] <= pm_pipe[i-1];
  end
  assign pm_final_out = pm_pipe[MULT_LAT-1];

  always @(negedge clk) begin
    int rel;
    if (rst) begin
      check("reset_outputs", {busy, done, w_rd, w_addr, pm_en, pm_weight_bits, res_valid, res_data, res_idx}, 64'h0);
      prev_rd = 1'b0;
    end else begin
      rel = cyc - t0;
      check("pm_en", pm_en, prev_rd);
      check("pm_weight_bits", pm_weight_bits, prev_rd ? mem[prev_addr] : 16'h0);
      if (w_rd) begin
        check("w_rd_in_range", n_issued < exp_n, 1);
        check("w_addr", w_addr, (exp_base + n_issued) % 1024);
        wrd_rel.push_back(rel);
        wrd_addr.push_back(int'(w_addr));
        n_issued++;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL res_unexpected: got idx %0d expected none", res_idx);
        end else begin
          check("res_data", res_data, exp_q[0].d);
          check("res_idx", res_idx, exp_q[0].i);
          void'(exp_q.pop_front());
        end
        res_rel.push_back(rel);
        res_idx_q.push_back(int'(res_idx));
        n_popped++;
      end
      check("outstanding_le_depth", (n_issued - n_popped) <= DEPTH, 1);
      if (done) done_rel.push_back(rel);
      if (busy) busy_cnt++;
      prev_rd = w_rd;
      prev_addr = w_addr;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic launch(input logic [9:0] b, input logic [7:0] n);
    tick();
    t0 = cyc; exp_base = int'(b); exp_n = int'(n); n_issued = 0; n_popped = 0; busy_cnt = 0;
    wrd_rel.delete(); wrd_addr.delete(); res_rel.delete(); res_idx_q.delete(); done_rel.delete();
    exp_q.delete();
    for (int r = 0; r < int'(n); r++) exp_q.push_back({pm_func(mem[(int'(b) + r) % 1024]), 8'(r)});
    start = 1'b1; base_addr = b; num_rows = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_rel.size() == 0 && k < budget) begin tick(); k++; end
    if (done_rel.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
    tick();
    check({name, "_all_delivered"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1);
  end

  initial begin
    int k;
    for (int a = 0; a < 1024; a++) mem[a] = (a < 64) ? ((a % 2) ? 16'hAAAA : 16'h5555) : 16'($urandom);
    check("model_even_row", pm_func(mem[0]), 16'hFFF8);
    check("model_odd_row", pm_func(mem[1]), 16'h0008);

    repeat (3) tick();
    check("reset_state", {busy, done, w_rd, w_addr, pm_en, pm_weight_bits, res_valid, res_data, res_idx}, 64'h0);
    rst = 1'b0;
    tick();

    // Streaming, no backpressure
    res_ready = 1'b1;
    launch(10'd0, 8'd16);
    repeat (4) tick();
    check("stream_first_valid", res_valid, 1);
    check("stream_first_data", res_data, 16'hFFF8);
    check("stream_first_idx", res_idx, 0);
    tick();
    check("stream_second_data", res_data, 16'h0008);
    check("stream_second_idx", res_idx, 1);
    wait_done("stream", 100);
    check("stream_wrd_count", wrd_rel.size(), 16);
    check("stream_wrd_first", wrd_rel[0], 1);
    check("stream_wrd_last", wrd_rel[15], 16);
    check("stream_res_first", res_rel[0], 5);
    check("stream_res_last", res_rel[15], 20);
    check("stream_done_cycle", done_rel[0], 21);
    check("stream_res_count", res_rel.size(), 16);

    // Backpressure
    res_ready = 1'b0;
    launch(10'd0, 8'd10);
    repeat (19) tick();
    check("bp_wrd_before_stall", wrd_rel.size(), 4);
    check("bp_stalled_busy", busy, 1);
    res_ready = 1'b1;
    wait_done("bp", 100);
    check("bp_resume_wrd", wrd_rel[4], 20);
    check("bp_first_res", res_rel[0], 20);
    check("bp_res_count", res_rel.size(), 10);
    check("bp_last_idx", res_idx_q[9], 9);
    check("bp_done_cycle", done_rel[0], 30);

    // Zero rows
    launch(10'd5, 8'd0);
    wait_done("zero", 20);
    check("zero_done_cycle", done_rel[0], 1);
    check("zero_no_wrd", wrd_rel.size(), 0);
    check("zero_no_busy", busy_cnt, 0);

    // Address wrap
    launch(10'd1022, 8'd4);
    wait_done("wrap", 50);
    check("wrap_addr0", wrd_addr[0], 1022);
    check("wrap_addr1", wrd_addr[1], 1023);
    check("wrap_addr2", wrd_addr[2], 0);
    check("wrap_addr3", wrd_addr[3], 1);
    check("wrap_done_cycle", done_rel[0], 9);

    // Start pulse while running
    launch(10'd200, 8'd8);
    tick(); tick();
    start = 1'b1; base_addr = 10'd0; num_rows = 8'd50;
    tick();
    start = 1'b0;
    wait_done("restart", 100);
    repeat (4) tick();
    check("restart_done_count", done_rel.size(), 1);
    check("restart_wrd_count", wrd_rel.size(), 8);
    check("restart_last_addr", wrd_addr[7], 207);
    check("restart_done_cycle", done_rel[0], 13);

    // Random backpressure over a full 255-row pass
    launch(10'd300, 8'd255);
    k = 0;
    while (done_rel.size() == 0 && k < 5000) begin
      tick(); k++;
      res_ready = 1'($urandom_range(0, 1));
    end
    res_ready = 1'b1;
    wait_done("random", 20);
    check("random_res_count", res_rel.size(), 255);
    check("random_last_idx", res_idx_q[254], 254);

    // Reset in the middle of a pass, then a short clean pass
    launch(10'd0, 8'd16);
    tick(); tick();
    check("midreset_was_issuing", w_rd, 1);
    rst = 1'b1;
    exp_q.delete(); exp_n = 0; n_issued = 0; n_popped = 0;
    #1;
    check("midreset_outputs", {busy, done, w_rd, w_addr, pm_en, pm_weight_bits, res_valid, res_data, res_idx}, 64'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    launch(10'd0, 8'd2);
    wait_done("post_reset", 50);
    check("post_reset_count", res_idx_q.size(), 2);
    check("post_reset_idx0", res_idx_q[0], 0);
    check("post_reset_idx1", res_idx_q[1], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pm_row_sched.md
# pm_row_sched

Row scheduler for the `parallel_mult` datapath. On `start` it walks a range of binary weight rows in weight memory, one row per output neuron. Each row is presented to `parallel_mult` as a 16-bit `weight_bits` word with `en`. Each `FinalOut` result is captured into a small output FIFO and streamed out with valid/ready handshaking, tagged by row index. Credit-based issue guarantees no result is ever dropped under backpressure.

## Interface
- `ADDR_W`, default 10: weight memory address width.
- `MULT_LAT`, default 2: `parallel_mult` latency in cycles, from an `en`-high cycle to a valid `FinalOut`; must be ≥1.
- `FIFO_DEPTH`, default 4: result FIFO entries; power of two, ≥2.
- `clk`, input, 1: single clock, all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: launch a layer pass; sampled only when idle.
- `base_addr`, input, ADDR_W: weight address of row 0; captured on accepted `start`.
- `num_rows`, input, 8: rows to process, 0..255; captured on accepted `start`.
- `busy`, output, 1: pass in progress.
- `done`, output, 1: one-cycle pulse at the end of a pass.
- `w_rd`, output, 1: weight memory read strobe.
- `w_addr`, output, ADDR_W: read address; `base_addr + row`, modulo 2^ADDR_W.
- `w_data`, input, 16: read data, valid the cycle after `w_rd`.
- `pm_en`, output, 1: drives `parallel_mult.en`.
- `pm_weight_bits`, output, 16: drives `parallel_mult.weight_bits`.
- `pm_final_out`, input, 16: from `parallel_mult.FinalOut`.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_data`, output, 16: result value.
- `res_idx`, output, 8: row index of `res_data`.

## Operation
- States:
  - IDLE: `start` with `num_rows != 0` goes to RUN. `start` with `num_rows == 0` goes to FIN.
  - RUN: issue rows. After the last issue, go to DRAIN.
  - DRAIN: wait until inflight = 0 and the FIFO is empty, then go to FIN.
  - FIN: `done` = 1, then return to IDLE.
- `start` is ignored outside IDLE.
- Issue condition in RUN: `issued < num_rows` and `(fifo_count + inflight) < FIFO_DEPTH`.
  - inflight counts rows with `w_rd` issued but not yet written into the FIFO.
  - On issue: `w_rd` = 1, `w_addr` = `base_addr + issued`, `issued` increments.
- Cycle after each `w_rd`: `pm_en` = 1 and `pm_weight_bits` = `w_data` (combinational pass of the registered read). Otherwise `pm_en` = 0 and `pm_weight_bits` = 0.
- Capture: a tap line of length MULT_LAT carries valid and row index alongside the pipeline. When the tap emerges, `pm_final_out` and the index are written into the FIFO.
  - Same-cycle FIFO write and FIFO read are both allowed.
  - The credit rule makes overflow impossible.
- `res_valid` = FIFO not empty; `res_data`/`res_idx` = FIFO head. Pop on `res_valid & res_ready`.
- Results leave in row order: `res_idx` = 0, 1, …, `num_rows-1`.
- `busy` = 1 in RUN and DRAIN. `busy` = 0 in IDLE and FIN.
- Reset, asynchronous at any time:
  - State returns to IDLE.
  - Counters, tap line, FIFO pointers cleared; in-flight results discarded.
  - All outputs 0.

## Timing
- Reset value of every output: 0 (`busy`, `done`, `w_rd`, `w_addr`, `pm_en`, `pm_weight_bits`, `res_valid`, `res_data`, `res_idx`).
- `start` sampled high in cycle 0 (IDLE) → RUN in cycle 1 → first `w_rd` in cycle 1.
- Per row, with `w_rd` in cycle t:
  - cycle t+1: `pm_en`.
  - cycle t+1+MULT_LAT: `pm_final_out` valid, written to the FIFO at the end of that cycle.
  - cycle t+2+MULT_LAT: `res_valid` high, if that row is at the FIFO head.
- First `res_valid` comes MULT_LAT+3 cycles after the `start` cycle (cycle 5 at defaults).
- With `res_ready` held at 1: one row issued per cycle, one result per cycle, no bubbles.
- With `res_ready` at 0: at most FIFO_DEPTH rows outstanding; issue stalls, and `w_rd`/`pm_en` stay 0 while stalled.
- Final handshake in cycle k: DRAIN → FIN, `done` = 1 in cycle k+1, IDLE in cycle k+2. A new `start` is accepted in cycle k+2.
- `num_rows` = 0: `done` in cycle 1; no `w_rd`; `busy` never asserted.
- `w_addr` wraps modulo 2^ADDR_W: `base_addr` = 1022 with 4 rows reads 1022, 1023, 0, 1.

## Test plan
- Reset state: assert `rst` mid-pass (cycle 3 of a 16-row pass) → all outputs 0 in the same cycle. After release, `start` with `num_rows` = 2 → `res_idx` = 0 then 1; no stale results.
- Streaming: `num_rows` = 16, `base_addr` = 0, memory row r = 0x5555 (r even) or 0xAAAA (r odd), `res_ready` = 1, reference `parallel_mult` model, input neurons i + 0x27CF →
  - `w_rd` cycles 1–16;
  - `res_valid` cycles 5–20, `res_idx` 0..15, `res_data` matches the model;
  - `done` in cycle 21.
- Backpressure: `num_rows` = 10, `res_ready` = 0 until cycle 20, then 1 → exactly 4 `w_rd` before the stall. All 10 results are delivered in order, none lost or duplicated.
- Toggling `res_ready` at random (50%), `num_rows` = 255 → 255 ordered results. `fifo_count + inflight` never exceeds 4.
- Edge cases:
  - `num_rows` = 0 → `done` in cycle 1, no `w_rd`.
  - `base_addr` = 1022, `num_rows` = 4 → addresses 1022, 1023, 0, 1.
- `start` pulsed during RUN → ignored; `base_addr`/`num_rows` unchanged; exactly one `done`.
